// File: rtl/bin_gray_pkg.sv
// Shared constants and helpers for the slow-edge binary/Gray stepper.
// Holds default sizes, count direction codes and the bin2gray function.
package bin_gray_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Widest counter bin2gray can encode; callers zero-extend and truncate.
  localparam int GRAY_MAX_W = 32;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Zero-extension is harmless: the top Gray bit becomes b[msb] ^ 0.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(
    input logic [GRAY_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain plus rising-edge detector for an async level input.
// Ports: clk, rst (sync, active-high), i_async level in, o_step 1-cycle pulse.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_step
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_step = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/bin_gray_stepper.sv
// Steps a binary counter on each rising edge of a slow square wave sampled
// in the clk domain and presents the count in binary and Gray code.
// Ports: clk, rst (sync, active-high), slow_clk (async level), en, up_dn,
//   load, load_val[WIDTH], bin_out[WIDTH], gray_out[WIDTH], step_o, wrap_o.
// Optional macro GRAY_CHECK_EN adds sticky output gray_err, set when a
//   step-driven update changes gray_out in other than exactly one bit.
module bin_gray_stepper
  import bin_gray_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             step_o,
  output logic             wrap_o
`ifdef GRAY_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  logic             w_step;
  logic             w_step_upd;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_dec_inc;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_step;
  logic             r_wrap;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (slow_clk),
    .o_step  (w_step)
  );

  always_comb begin
    w_dec_inc  = (up_dn == DIR_DN) ? r_bin - WIDTH'(1)
                                   : r_bin + WIDTH'(1);
    // Load wins over a coincident step; that step is simply dropped.
    w_step_upd = w_step & en & ~load;
    w_wrap_nxt = w_step_upd &
                 ((up_dn == DIR_UP) ? (&r_bin) : ~(|r_bin));
    w_bin_nxt  = r_bin;
    if (load)
      w_bin_nxt = load_val;
    else if (w_step_upd)
      w_bin_nxt = w_dec_inc;
  end

  // Gray is encoded from the next binary value so both land together.
  assign w_gray_nxt = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_nxt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_step <= w_step;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign step_o   = r_step;
  assign wrap_o   = r_wrap;

`ifdef GRAY_CHECK_EN
  logic r_gray_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_gray_err <= 1'b0;
    else if (w_step_upd &&
             ($countones(r_gray ^ w_gray_nxt) != 1))
      r_gray_err <= 1'b1;
  end

  assign gray_err = r_gray_err;
`endif

endmodule

// File: tb/tb_bin_gray_stepper.sv
// Directed bench for bin_gray_stepper (WIDTH=4, SYNC_STAGES=2).
// Table of edge/load records plus hand sequences for multi-cycle cases.
module tb_bin_gray_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_clk;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bin_out;
  logic [3:0] gray_out;
  logic       step_o;
  logic       wrap_o;
`ifdef GRAY_CHECK_EN
  logic       gray_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_steps = 0;
  bit inv_en = 1'b0;

  always #5 clk = ~clk;

  bin_gray_stepper #(
    .WIDTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .step_o   (step_o),
    .wrap_o   (wrap_o)
`ifdef GRAY_CHECK_EN
    ,
    .gray_err (gray_err)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) if (step_o) n_steps++;

  always @(negedge clk)
    if (inv_en)
      chk("gray_inv", int'(gray_out), int'(bin_out ^ (bin_out >> 1)));

  // Raise slow_clk and return at the first negedge showing step_o.
  task automatic rise_wait(output int lat);
    lat = 0;
    slow_clk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (step_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic fall_quiet();
    int s0;
    @(negedge clk);
    chk("step_pulse_len", int'(step_o), 0);
    chk("wrap_pulse_len", int'(wrap_o), 0);
    slow_clk = 1'b0;
    s0 = n_steps;
    repeat (4) @(negedge clk);
    chk("fall_no_step", n_steps - s0, 0);
  endtask

  typedef struct {
    bit       is_load;
    bit       en;
    bit       up;
    bit [3:0] val;
    bit [3:0] eb;
    bit [3:0] eg;
    bit       ew;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int lat;
    int s0;

    tbl[0]  = '{0, 1, 1, 4'h0, 4'h1, 4'h1, 0};
    tbl[1]  = '{0, 1, 1, 4'h0, 4'h2, 4'h3, 0};
    tbl[2]  = '{0, 1, 1, 4'h0, 4'h3, 4'h2, 0};
    tbl[3]  = '{0, 1, 1, 4'h0, 4'h4, 4'h6, 0};
    tbl[4]  = '{0, 1, 1, 4'h0, 4'h5, 4'h7, 0};
    tbl[5]  = '{1, 1, 1, 4'hF, 4'hF, 4'h8, 0};
    tbl[6]  = '{0, 1, 1, 4'h0, 4'h0, 4'h0, 1};
    tbl[7]  = '{0, 1, 0, 4'h0, 4'hF, 4'h8, 1};
    tbl[8]  = '{1, 0, 1, 4'h6, 4'h6, 4'h5, 0};
    tbl[9]  = '{0, 0, 1, 4'h0, 4'h6, 4'h5, 0};
    tbl[10] = '{0, 0, 0, 4'h0, 4'h6, 4'h5, 0};
    tbl[11] = '{0, 0, 1, 4'h0, 4'h6, 4'h5, 0};
    tbl[12] = '{0, 1, 0, 4'h0, 4'h5, 4'h7, 0};
    tbl[13] = '{0, 1, 1, 4'h0, 4'h6, 4'h5, 0};

    rst = 1'b1;
    slow_clk = 1'b0;
    en = 1'b0;
    up_dn = 1'b1;
    load = 1'b0;
    load_val = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_gray", int'(gray_out), 0);
    chk("rst_step", int'(step_o), 0);
    chk("rst_wrap", int'(wrap_o), 0);
    rst = 1'b0;
    inv_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_step", n_steps, 0);

    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      up_dn = tbl[i].up;
      if (tbl[i].is_load) begin
        load = 1'b1;
        load_val = tbl[i].val;
        @(negedge clk);
        load = 1'b0;
        chk($sformatf("v%0d_bin", i), int'(bin_out), int'(tbl[i].eb));
        chk($sformatf("v%0d_gray", i), int'(gray_out), int'(tbl[i].eg));
        chk($sformatf("v%0d_wrap", i), int'(wrap_o), 0);
        repeat (2) @(negedge clk);
      end else begin
        rise_wait(lat);
        chk($sformatf("v%0d_lat", i), lat, 3);
        chk($sformatf("v%0d_bin", i), int'(bin_out), int'(tbl[i].eb));
        chk($sformatf("v%0d_gray", i), int'(gray_out), int'(tbl[i].eg));
        chk($sformatf("v%0d_wrap", i), int'(wrap_o), int'(tbl[i].ew));
        fall_quiet();
      end
    end
    chk("table_steps", n_steps, 12);

    // Load coincident with a step: load value wins, no increment.
    en = 1'b1;
    up_dn = 1'b1;
    slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b1;
    load_val = 4'h9;
    @(negedge clk);
    load = 1'b0;
    chk("ldstep_step", int'(step_o), 1);
    chk("ldstep_bin", int'(bin_out), 9);
    chk("ldstep_gray", int'(gray_out), 13);
    chk("ldstep_wrap", int'(wrap_o), 0);
    @(negedge clk);
    chk("ldstep_hold", int'(bin_out), 9);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk);

    // Long high / long low level: exactly one step.
    s0 = n_steps;
    slow_clk = 1'b1;
    repeat (1000) @(negedge clk);
    slow_clk = 1'b0;
    repeat (1000) @(negedge clk);
    chk("long_steps", n_steps - s0, 1);
    chk("long_bin", int'(bin_out), 10);
    chk("long_gray", int'(gray_out), 15);

    // Reset while the step is asserted: the edge is discarded.
    slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    slow_clk = 1'b0;
    @(negedge clk);
    chk("rstfly_step", int'(step_o), 0);
    chk("rstfly_bin", int'(bin_out), 0);
    rst = 1'b0;
    s0 = n_steps;
    repeat (8) @(negedge clk);
    chk("rstfly_quiet", n_steps - s0, 0);
    chk("rstfly_bin2", int'(bin_out), 0);

    // slow_clk already high at reset release yields one step.
    slow_clk = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (step_o) begin
        lat = k;
        break;
      end
    end
    chk("hirel_lat", lat, 3);
    chk("hirel_bin", int'(bin_out), 1);
    chk("hirel_gray", int'(gray_out), 1);
    fall_quiet();

`ifdef GRAY_CHECK_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) up_dn = 1'b0;
      rise_wait(lat);
      slow_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("sweep_bin", int'(bin_out), 0);
    chk("sweep_err", int'(gray_err), 0);
    inv_en = 1'b0;
    up_dn = 1'b1;
    slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    force dut.w_gray_nxt = 4'b0011;
    @(negedge clk);
    release dut.w_gray_nxt;
    slow_clk = 1'b0;
    chk("force_err", int'(gray_err), 1);
    repeat (5) @(negedge clk);
    chk("force_sticky", int'(gray_err), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", int'(gray_err), 0);
`endif

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bin_gray_stepper.md
Name: bin_gray_stepper

Overview:
- Sits directly downstream of the 1 Hz divider, whose slow square-wave output drives `slow_clk`.
- Samples that square wave in the fast system clock domain and detects its rising edges.
- Steps a WIDTH-bit binary counter on each detected edge and presents the count in both binary and Gray code to the board LEDs.
- Never uses the slow signal as a clock; everything runs on `clk`.

Parameters:
- WIDTH, 4, counter width in bits; also the width of `bin_out`, `gray_out` and `load_val`.
- SYNC_STAGES, 2, number of synchronizer flops on `slow_clk` before edge detection; legal range 2..4.

Ports:
- clk  input  1  system clock (100 MHz board clock).
- rst  input  1  synchronous active-high reset.
- slow_clk  input  1  divided square wave from the 1 Hz divider; asynchronous to `clk` for timing purposes.
- en  input  1  1 = counter steps on detected edges; 0 = count holds.
- up_dn  input  1  1 = count up, 0 = count down; sampled on the step cycle.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written to the counter when `load` = 1.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of `bin_out`.
- step_o  output  1  one-cycle pulse marking a detected `slow_clk` rising edge.
- wrap_o  output  1  one-cycle pulse when the counter wraps.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rst` is synchronous, active-high and overrides everything.
- Reset values:
  - `bin_out` = 0, `gray_out` = 0, `step_o` = 0, `wrap_o` = 0.
  - All synchronizer flops = 0, so a `slow_clk` that is already high at reset release produces one edge after the sync delay.
- Synchronizer and edge detect:
  - `slow_clk` passes through a SYNC_STAGES-deep flop chain, then one extra history flop.
  - `step` = last sync stage AND NOT history flop.
  - `step_o` is `step` registered.
- Latency (SYNC_STAGES = 2):
  - `slow_clk` high before edge E0.
  - `step` is high in the cycle after E1.
  - `bin_out`, `gray_out` and `step_o` update at E2.
  - In general, E(SYNC_STAGES).
- Exactly one step per `slow_clk` rising edge. Falling edges and a constant level produce no steps.
- Counter update priority, highest first:
  1. `rst`.
  2. `load`: `bin_out` <= `load_val`. Loads even when `en` = 0. A coincident step is dropped, with no increment after load.
  3. `step` AND `en`: `bin_out` <= `bin_out` +1 if `up_dn`, else −1.
  4. Otherwise hold.
- Wrap rules:
  - Up from 2^WIDTH−1 gives 0; down from 0 gives 2^WIDTH−1.
  - Modulo 2^WIDTH arithmetic, no saturation.
  - `wrap_o` pulses for 1 cycle, coincident with the wrapped value appearing.
  - A load never asserts `wrap_o`.
- `step_o` pulses regardless of `en` and `load`.
- Gray encoding:
  - `gray_out` is computed from the next `bin_out` value and registered on the same edge.
  - Invariant at every cycle: `gray_out` == `bin_out` ^ (`bin_out` >> 1).
- Reset asserted mid-operation clears the counter and the sync chain on the next edge. A step that is in flight is discarded.

Optional Feature:
- Macro: GRAY_CHECK_EN.
- With the macro defined:
  - Adds output `gray_err` (1 bit, reset 0).
  - Asserted and sticky until `rst` when a step-driven update changes `gray_out` in a number of bits other than exactly 1.
  - Load-driven updates are excluded from the check.
- Without the macro: the port and its logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package `bin_gray_pkg` holds:
  - The default WIDTH and SYNC_STAGES constants.
  - A `bin2gray` function of parameterised width.
  - Direction constants DIR_UP = 1, DIR_DN = 0.
- One sub-module: `edge_sync`. It contains the synchronizer chain plus rising-edge detector and outputs the single-cycle `step`. It is reusable for push-buttons elsewhere on the board.

Test Plan:
- Reset then 5 `slow_clk` rising edges, with `en`=1, `up_dn`=1, WIDTH=4 -> `bin_out` 0→5, `gray_out` sequence 0,1,3,2,6,7; `step_o` pulses exactly 5 times, each 2 clk after the synchronized edge.
- `load`=1 with `load_val`=4'hF, then 1 up step -> `bin_out`=0, `gray_out`=0, `wrap_o`=1 for one cycle. Then `up_dn`=0 and 1 step -> `bin_out`=F, `gray_out`=4'h8, `wrap_o` pulses again.
- `en`=0 across 3 edges with `bin_out`=6 -> `bin_out` stays 6, `step_o` still pulses 3 times, no `wrap_o`.
- `load`=1 with `load_val`=9 in the same cycle as `step` -> `bin_out`=9 (not 10), `gray_out`=4'hD, `wrap_o`=0.
- `slow_clk` held high for 1000 cycles then low for 1000 cycles -> exactly one step. Assert `rst` 1 cycle after `step` -> `bin_out`=0, no subsequent update from that edge.
- GRAY_CHECK_EN defined, full 16-step up sweep plus 16-step down sweep -> `gray_err` stays 0. Force an illegal 2-bit jump via a bench `force` -> `gray_err`=1 and remains 1 until `rst`.
